// File: rtl/keccak_rho_seq_if.sv
// Handshake bundle for keccak_rho_seq: one valid/ready stream of 25-lane states in,
// one valid/ready stream of rotated states out.
interface keccak_rho_seq_if #(
  parameter int W = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [25*W-1:0] in_state;
  logic            out_valid;
  logic            out_ready;
  logic [25*W-1:0] out_state;

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );
endinterface

// File: rtl/keccak_rho_seq.sv
// Sequential Keccak rho step: LPC lanes rotated per cycle, N = 25/LPC busy cycles per state.
// Optional feature macro KECCAK_RHO_PI_EN: applies the pi lane permutation in the same write.
module keccak_rho_seq #(
  parameter int W   = 64,
  parameter int LPC = 5
) (
  input  logic            clk,
  input  logic            rst,
  keccak_rho_seq_if.slave bus
);

  localparam int         SW      = 25 * W;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [5:0] LPC_INC = 6'(LPC);
  localparam logic [5:0] LANES   = 6'd25;

  // Rotation offsets indexed by x + 5*y.
  localparam int RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  generate
    if (!(W == 8 || W == 16 || W == 32 || W == 64)) begin : g_bad_w
      $error("keccak_rho_seq: W must be 8, 16, 32 or 64");
    end
    if (!(LPC == 1 || LPC == 5 || LPC == 25)) begin : g_bad_lpc
      $error("keccak_rho_seq: LPC must be 1, 5 or 25");
    end
  endgenerate

  // Upper half of the doubled lane shifted left is the left rotation; r = 0 yields v.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
    logic [2*W-1:0] t;
    t = {v, v} << r;
    return t[2*W-1:W];
  endfunction

`ifdef KECCAK_RHO_PI_EN
  function automatic int lane_dst(input int i);
    int x;
    int y;
    x = i % 5;
    y = i / 5;
    return y + 5 * ((2 * x + 3 * y) % 5);
  endfunction
`else
  function automatic int lane_dst(input int i);
    return i;
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [SW-1:0] in_q, in_d;
  logic [SW-1:0] res_q, res_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [5:0]    cnt_end_s;
  logic [W-1:0]  rot_s [25];

  assign cnt_end_s = {1'b0, cnt_q} + LPC_INC;

  always_comb begin
    for (int i = 0; i < 25; i++) begin
      rot_s[i] = rotl(in_q[i*W +: W], RHO[i] % W);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_d        = in_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = BUSY;
          in_d       = bus.in_state;
          cnt_d      = 5'd0;
          in_ready_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // Only lanes inside the current window [cnt, cnt+LPC) are overwritten.
        for (int i = 0; i < 25; i++) begin
          res_d[lane_dst(i)*W +: W] =
            ((6'(i) >= {1'b0, cnt_q}) && (6'(i) < cnt_end_s)) ? rot_s[i]
                                                              : res_d[lane_dst(i)*W +: W];
        end
        cnt_d = cnt_end_s[4:0];
        if (cnt_end_s >= LANES) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 5'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      in_q        <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_q        <= in_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = res_q;

endmodule

// File: tb/tb_keccak_rho_seq.sv
// Self-checking bench for keccak_rho_seq: five configurations side by side, checked
// against a bit-level rho (and optional pi) reference model.
module tb_keccak_rho_seq;

  localparam int WS [5] = '{64,  8, 64, 64, 32};
  localparam int LS [5] = '{ 1, 25,  5, 25,  5};
  localparam int RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };
`ifdef KECCAK_RHO_PI_EN
  localparam bit PI = 1'b1;
`else
  localparam bit PI = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          iv   [5];
  logic          ordy [5];
  logic [1599:0] ist  [5];
  logic          ir   [5];
  logic          ov   [5];
  logic [1599:0] ost  [5];

  int passed;
  int total;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    keccak_rho_seq_if #(.W(WS[k])) bus ();
    keccak_rho_seq #(.W(WS[k]), .LPC(LS[k])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.in_valid  = iv[k];
    assign bus.in_state  = ist[k][25*WS[k]-1:0];
    assign bus.out_ready = ordy[k];
    assign ir[k]  = bus.in_ready;
    assign ov[k]  = bus.out_valid;
    assign ost[k] = 1600'(bus.out_state);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: out[z] = in[(z - r) mod w], lane placed at its own or its pi position.
  function automatic logic [1599:0] model(input logic [1599:0] st, input int w);
    logic [1599:0] o;
    int r, d, x, y;
    o = '0;
    for (int i = 0; i < 25; i++) begin
      x = i % 5;
      y = i / 5;
      r = RHO[i] % w;
      d = PI ? (y + 5 * ((2 * x + 3 * y) % 5)) : i;
      for (int z = 0; z < w; z++) o[d*w + z] = st[i*w + ((z - r + w) % w)];
    end
    return o;
  endfunction

  function automatic logic [1599:0] rand_state(input int w);
    logic [1599:0] s;
    for (int j = 0; j < 50; j++) s[j*32 +: 32] = $urandom();
    for (int b = 25 * w; b < 1600; b++) s[b] = 1'b0;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int k, input logic [1599:0] st, output bit ok);
    ist[k] = st;
    iv[k]  = 1'b1;
    ok     = ir[k];
    step();
    iv[k]  = 1'b0;
  endtask

  task automatic wait_ov(input int k, input int max, output int n);
    n = 0;
    while (!ov[k] && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (ir[k] !== 1'b1) $display("FAIL reset_in_ready[%0d]: got %b expected 1", k, ir[k]);
      else passed++;
      total++;
      if (ov[k] !== 1'b0) $display("FAIL reset_out_valid[%0d]: got %b expected 0", k, ov[k]);
      else passed++;
      total++;
      if (ost[k] !== '0) $display("FAIL reset_out_state[%0d]: got %h expected 0", k, ost[k]);
      else passed++;
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_lpc1_lane1();
    logic [1599:0] st;
    bit ok;
    int n;
    st = '0;
    st[64] = 1'b1;
    accept(0, st, ok);
    total++;
    if (ok !== 1'b1) $display("FAIL lpc1_accept: got %b expected 1", ok); else passed++;
    wait_ov(0, 40, n);
    total++;
    if (n != 25) $display("FAIL lpc1_latency: got %0d expected 25", n); else passed++;
    total++;
    if (ost[0] !== model(st, 64)) $display("FAIL lpc1_model: got %h expected %h", ost[0], model(st, 64));
    else passed++;
`ifndef KECCAK_RHO_PI_EN
    total++;
    if (ost[0] !== (1600'(64'h2) << 64))
      $display("FAIL lpc1_lane1: got %h expected lane1=2 only", ost[0]);
    else passed++;
`endif
    ordy[0] = 1'b1;
    step();
    ordy[0] = 1'b0;
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1)
      $display("FAIL lpc1_release: got ov=%b ir=%b expected ov=0 ir=1", ov[0], ir[0]);
    else passed++;
  endtask

  task automatic test_w8_single_cycle();
    logic [1599:0] st;
    bit ok;
    int n;
    st = '0;
    st[7:0]   = 8'hA5;
    st[23:16] = 8'h01;
    accept(1, st, ok);
    wait_ov(1, 40, n);
    total++;
    if (n != 1) $display("FAIL w8_latency: got %0d expected 1", n); else passed++;
`ifndef KECCAK_RHO_PI_EN
    total++;
    if (ost[1] !== ((1600'(8'h40) << 16) | 1600'(8'hA5)))
      $display("FAIL w8_lanes: got %h expected lane0=a5 lane2=40", ost[1]);
    else passed++;
`endif
    total++;
    if (ost[1] !== model(st, 8)) $display("FAIL w8_model: got %h expected %h", ost[1], model(st, 8));
    else passed++;
    ordy[1] = 1'b1;
    step();
    ordy[1] = 1'b0;
  endtask

  task automatic test_stall();
    logic [1599:0] st, exp_s;
    bit ok;
    int n;
    st    = rand_state(64);
    exp_s = model(st, 64);
    ordy[2] = 1'b0;
    accept(2, st, ok);
    ist[2] = rand_state(64);
    iv[2]  = 1'b1;
    wait_ov(2, 40, n);
    total++;
    if (n != 5) $display("FAIL stall_latency: got %0d expected 5", n); else passed++;
    for (int c = 0; c < 10; c++) begin
      total++;
      if (ov[2] !== 1'b1) $display("FAIL stall_out_valid c%0d: got %b expected 1", c, ov[2]);
      else passed++;
      total++;
      if (ost[2] !== exp_s) $display("FAIL stall_out_state c%0d: got %h expected %h", c, ost[2], exp_s);
      else passed++;
      total++;
      if (ir[2] !== 1'b0) $display("FAIL stall_in_ready c%0d: got %b expected 0", c, ir[2]);
      else passed++;
      ist[2] = rand_state(64);
      step();
    end
    ordy[2] = 1'b1;
    step();
    ordy[2] = 1'b0;
    iv[2]   = 1'b0;
    total++;
    if (ir[2] !== 1'b1 || ov[2] !== 1'b0)
      $display("FAIL stall_single_accept: got ir=%b ov=%b expected ir=1 ov=0", ir[2], ov[2]);
    else passed++;
  endtask

  task automatic test_reset_busy();
    bit ok;
    bit seen;
    accept(2, rand_state(64), ok);
    step();
    step();
    rst     = 1'b1;
    ordy[2] = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (ir[2] !== 1'b1 || ov[2] !== 1'b0 || ost[2] !== '0)
      $display("FAIL busy_reset: got ir=%b ov=%b state=%h expected ir=1 ov=0 state=0", ir[2], ov[2], ost[2]);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (ov[2] === 1'b1) seen = 1'b1;
    end
    ordy[2] = 1'b0;
    total++;
    if (seen !== 1'b0) $display("FAIL busy_reset_no_pulse: got %b expected 0", seen); else passed++;
  endtask

  task automatic test_pi();
`ifdef KECCAK_RHO_PI_EN
    logic [1599:0] st;
    bit ok;
    int n;
    st = '0;
    st[64] = 1'b1;
    accept(3, st, ok);
    wait_ov(3, 40, n);
    total++;
    if (n != 1) $display("FAIL pi_latency: got %0d expected 1", n); else passed++;
    total++;
    if (ost[3] !== (1600'(64'h2) << 640))
      $display("FAIL pi_lane10: got %h expected lane10=2 only", ost[3]);
    else passed++;
    ordy[3] = 1'b1;
    step();
    ordy[3] = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic [1599:0] st;
    bit ok;
    int n;
    for (int k = 0; k < 5; k++) begin
      for (int rep = 0; rep < 2; rep++) begin
        st = rand_state(WS[k]);
        accept(k, st, ok);
        wait_ov(k, 40, n);
        total++;
        if (n != 25 / LS[k]) $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, n, 25 / LS[k]);
        else passed++;
        total++;
        if (ost[k] !== model(st, WS[k]))
          $display("FAIL rand_state[%0d]: got %h expected %h", k, ost[k], model(st, WS[k]));
        else passed++;
        ordy[k] = 1'b1;
        step();
        ordy[k] = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1599:0] q[$];
    logic [1599:0] exp_s;
    int last, nacc, nout;
    bit took;
    last = -1;
    nacc = 0;
    nout = 0;
    ist[4]  = rand_state(32);
    iv[4]   = 1'b1;
    ordy[4] = 1'b1;
    for (int c = 0; c < 64; c++) begin
      if (ov[4] === 1'b1) begin
        nout++;
        exp_s = (q.size() > 0) ? q.pop_front() : '0;
        total++;
        if (ost[4] !== exp_s) $display("FAIL b2b_state c%0d: got %h expected %h", c, ost[4], exp_s);
        else passed++;
      end
      took = (ir[4] === 1'b1);
      if (took) begin
        q.push_back(model(ist[4], 32));
        if (last >= 0) begin
          total++;
          if (c - last != 7) $display("FAIL b2b_interval c%0d: got %0d expected 7", c, c - last);
          else passed++;
        end
        last = c;
        nacc++;
      end
      step();
      if (took) ist[4] = rand_state(32);
    end
    iv[4] = 1'b0;
    for (int c = 0; c < 10; c++) step();
    ordy[4] = 1'b0;
    total++;
    if (nacc < 9 || nout < 8) $display("FAIL b2b_count: got acc=%0d out=%0d expected acc>=9 out>=8", nacc, nout);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      ist[k]  = '0;
    end
    test_reset();
    test_lpc1_lane1();
    test_w8_single_cycle();
    test_stall();
    test_reset_busy();
    test_pi();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keccak_rho_seq.md
KECCAK_RHO_SEQ -- requirements
Module: keccak_rho_seq

Interface
REQ-001 Parameter W, default 64, lane width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter LPC, default 5, lanes rotated per cycle; legal values 1, 5, 25.
REQ-003 Port clk, input, 1, single clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port in_valid, input, 1, in_state is valid.
REQ-006 Port in_ready, output, 1, block can accept a state.
REQ-007 Port in_state, input, 25*W, Keccak state; lane (x,y) occupies bits [(x+5y)*W +: W].
REQ-008 Port out_valid, output, 1, out_state is valid.
REQ-009 Port out_ready, input, 1, downstream accepts out_state.
REQ-010 Port out_state, output, 25*W, transformed state; lane layout as in_state.

Function
REQ-011 Each lane (x,y) SHALL be rotated left (toward MSB) by r[x,y] mod W: out[z] = in[(z - r) mod W].
REQ-012 The r table, indexed [x,y], SHALL be as follows; an offset of 0 mod W leaves the lane unchanged.
- y=0: 0 1 62 28 27
- y=1: 36 44 6 55 20
- y=2: 3 10 43 25 39
- y=3: 41 45 15 21 8
- y=4: 18 2 61 56 14
REQ-013 States are IDLE, BUSY and DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-014 IDLE to BUSY on in_valid && in_ready; the same edge captures in_state and clears the lane counter.
REQ-015 In BUSY, each edge SHALL:
- rotate lanes [cnt, cnt+LPC-1] into the result register;
- advance cnt by LPC.
REQ-016 BUSY SHALL last N = 25/LPC edges; the edge that processes the last lane moves the block to DONE.
REQ-017 Latency: out_valid SHALL rise exactly N edges after the accepting edge (LPC=25: 1 cycle; LPC=1: 25 cycles).
REQ-018 In DONE, out_state SHALL hold stable until out_valid && out_ready.
- That edge returns the block to IDLE.
- in_ready SHALL stay 0 during that edge; no same-cycle input is accepted.
REQ-019 in_valid or in_state changes while in BUSY or DONE SHALL be ignored.
REQ-020 out_ready asserted outside DONE SHALL have no effect.
REQ-021 An illegal W or LPC SHALL cause an elaboration-time error.

Reset
REQ-022 When rst = 1 at an edge, the block SHALL:
- enter IDLE;
- clear cnt and the result register;
- drive in_ready = 1 on the following cycle, with out_valid = 0 and out_state = 0.
REQ-023 Reset during BUSY or DONE SHALL discard the in-flight state; no out_valid pulse follows.
REQ-024 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-025 With macro KECCAK_RHO_PI_EN defined, the pi step SHALL follow rho in the same lane write.
- The lane (x,y) result goes to output lane (y, (2x+3y) mod 5).
- Latency and handshakes are unchanged.
REQ-026 With KECCAK_RHO_PI_EN undefined, lanes SHALL keep their (x,y) position and no pi logic is instantiated.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- W=64, LPC=1, pi off; only lane (1,0) = 0x1, others 0 -> out_valid 25 cycles after accept; lane 1 = 0x2; all other lanes 0.
- W=8, LPC=25, pi off; lane (2,0) = 0x01 -> after 1 cycle lane 2 = 0x40 (62 mod 8 = 6); lane (0,0) = 0xA5 -> unchanged.
- W=64, LPC=5, pi off; out_ready held 0 for 10 cycles after out_valid -> out_valid and out_state stable and in_ready = 0 throughout; one accept only.
- W=64, LPC=5; rst asserted on the 3rd BUSY cycle -> next cycle in_ready = 1, out_valid = 0, out_state = 0; no out_valid pulse follows.
- W=64, LPC=25, KECCAK_RHO_PI_EN defined; lane (1,0) = 0x1 -> output lane index 10, i.e. (0,2), = 0x2; all other lanes 0.
- Back-to-back transfers, W=32, LPC=5, in_valid and out_ready held 1 -> one accept every N+2 = 7 cycles; results match the reference model for random states.
